seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
//  Sequences one shared segment decoder across all digits. Per digit slot it drives
//  the 4-bit digit code to the decoder and the matching active-low anode. A blanking
//  gap between slots prevents ghosting. Display data is double-buffered: it updates
//  only at frame boundaries.
// PARAMETERS
//  N_DIG      4      number of digits scanned (2..8)
//  SLOT_CYC   50000  CLK cycles each digit is lit (>=2)
//  BLANK_CYC  16     CLK cycles all anodes are off between slots (>=1)
// PORTS
//  CLK       in   1          system clock, rising edge
//  RST_N     in   1          asynchronous active-low reset
//  EN        in   1          1 = scan, 0 = display off (IDLE)
//  DATA      in   4*N_DIG    digit codes; DATA[3:0] = digit 0 (rightmost)
//  LOAD      in   1          1-cycle strobe, captures DATA into pending buffer
//  PEND      out  1          pending buffer holds data not yet displayed
//  FRAME     out  1          1-cycle pulse when digit N_DIG-1 slot ends (frame done)
//  DIG_NUM   out  4          digit code to segment decoder
//  AN        out  N_DIG      anode enables, active-low, one-hot-zero
//  SEG_BLANK out  1          1 = force decoder output dark (all segments 1)
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, idx=0, counters=0, active=pending=0,
//    PEND=0, FRAME=0, DIG_NUM=0, AN=all 1, SEG_BLANK=1.
//  - FSM states IDLE, SHOW, GAP:
//    IDLE: AN=all 1, SEG_BLANK=1. EN=1 -> SHOW with idx=0, cnt=0.
//    SHOW: AN[idx]=0, DIG_NUM=active[idx], SEG_BLANK=0. After SLOT_CYC cycles -> GAP.
//    GAP:  AN=all 1, SEG_BLANK=1, DIG_NUM held. After BLANK_CYC cycles -> SHOW with
//          idx+1. At idx=N_DIG-1, idx wraps to 0 and FRAME pulses on the same edge.
//  - EN=0 in any state -> IDLE on the next edge. idx resets to 0; no FRAME pulse.
//  - Frame period = N_DIG*(SLOT_CYC+BLANK_CYC) cycles. The first AN low comes 1 cycle
//    after EN rises.
//  - LOAD: pending<=DATA, PEND<=1. A second LOAD before it is applied overwrites
//    pending (last wins).
//  - Apply: on a FRAME edge, or on any edge while IDLE, if PEND=1 then
//    active<=pending and PEND<=0.
//  - LOAD on the same edge as an apply: active<=DATA directly, PEND=0.
//  - Counter widths come from $clog2 of the parameters. Counters wrap exactly at
//    terminal count; no overflow states.
//  - Reset asserted mid-frame: all outputs return to reset values asynchronously.
//    Pending data is lost.
// CONFIGURATION
//  SEG_SCAN_LZB_EN defined: leading-zero blanking. While in SHOW, SEG_BLANK=1 for
//    digit idx when active[idx]==0 and every higher digit is also 0. Digit 0 is never
//    blanked. The AN timing is unchanged.
//  Not defined: SEG_BLANK=0 during every SHOW slot. All zeros are displayed.
// STRUCTURE
//  - Shared package seg_pkg: state encoding (IDLE=2'd0, SHOW=2'd1, GAP=2'd2),
//    DIGIT_W=4, BLANK_CODE=7'b1111111.
//  - One natural sub-module, seg_scan_timer: prescaler issuing slot_done/gap_done
//    pulses from SLOT_CYC/BLANK_CYC. The FSM, index and buffers stay in this module.
//  - The decoder is instantiated by the parent, not here.
// TESTING (N_DIG=4, SLOT_CYC=4, BLANK_CYC=2)
//  1. Reset, EN=0 -> AN=4'b1111, SEG_BLANK=1, DIG_NUM=0, PEND=0, FRAME=0.
//  2. LOAD DATA=16'h4321 in IDLE, then EN=1 -> AN cycles 1110,1101,1011,0111, each for
//     4 cycles with 2-cycle 1111 gaps. DIG_NUM=1,2,3,4. FRAME pulses every 24 cycles.
//  3. Mid-frame LOAD 16'hABCD -> PEND=1; the current frame still shows 4321. After the
//     FRAME edge, DIG_NUM shows D,C,B,A and PEND=0.
//  4. Two LOADs (16'h1111, then 16'h2222) before a boundary, one LOAD coincident with
//     FRAME -> last/direct value is displayed. No intermediate value ever appears.
//  5. EN dropped during digit 2 -> IDLE next edge, AN=1111, no FRAME. Re-enable ->
//     restarts at digit 0.
//  6. RST_N pulsed low mid-SHOW -> AN=1111 immediately. With SEG_SCAN_LZB_EN and
//     16'h0050: digits 3 and 2 are blanked, digit 0 (0) is lit.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants for the 7-segment scan controller
package seg_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Segment pattern the downstream decoder drives while SEG_BLANK is set
  localparam logic [6:0] BLANK_CODE = 7'b1111111;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - control and display bus between host and scan controller
interface seg_scan_ctrl_if
  import seg_pkg::*;
#(
  parameter int N_DIG = 4
);
  logic                       EN;
  logic [DIGIT_W*N_DIG-1:0]   DATA;
  logic                       LOAD;
  logic                       PEND;
  logic                       FRAME;
  logic [DIGIT_W-1:0]         DIG_NUM;
  logic [N_DIG-1:0]           AN;
  logic                       SEG_BLANK;

  modport master (
    output EN, DATA, LOAD,
    input  PEND, FRAME, DIG_NUM, AN, SEG_BLANK
  );

  modport slave (
    input  EN, DATA, LOAD,
    output PEND, FRAME, DIG_NUM, AN, SEG_BLANK
  );
endinterface

// File: rtl/seg_scan_timer.sv
// rtl/seg_scan_timer.sv - slot/gap prescaler; pulses on the last cycle of each phase
module seg_scan_timer #(
  parameter int SLOT_CYC  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic run_i,
  input  logic gap_i,
  output logic slot_done_o,
  output logic gap_done_o
);
  localparam int MAX_CYC = (SLOT_CYC > BLANK_CYC) ? SLOT_CYC : BLANK_CYC;
  localparam int CW      = $clog2(MAX_CYC);
  localparam logic [CW-1:0] SLOT_TC = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] GAP_TC  = CW'(BLANK_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tc;

  // Counter restarts at every phase boundary, so each phase owns the full count
  always_comb begin
    tc          = (cnt_q == (gap_i ? GAP_TC : SLOT_TC));
    slot_done_o = run_i && !gap_i && tc;
    gap_done_o  = run_i && gap_i && tc;
    cnt_d       = (!run_i || tc) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - N-digit multiplexed 7-segment scan FSM with double-buffered data
// Optional leading-zero blanking: define SEG_SCAN_LZB_EN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int N_DIG     = 4,
  parameter int SLOT_CYC  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic            CLK,
  input  logic            RST_N,
  seg_scan_ctrl_if.slave  bus
);
  localparam int IW = $clog2(N_DIG);
  localparam int DW = DIGIT_W * N_DIG;
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIG - 1);

  logic [1:0]         state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [DW-1:0]      active_q, active_d;
  logic [DW-1:0]      pending_q, pending_d;
  logic               pend_q, pend_d;
  logic               frame_q, frame_d;
  logic [DIGIT_W-1:0] dig_q, dig_d;
  logic [N_DIG-1:0]   an_q, an_d;
  logic               blank_q, blank_d;
  logic               slot_done, gap_done, apply;

  seg_scan_timer #(
    .SLOT_CYC  (SLOT_CYC),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .run_i       ((state_q != ST_IDLE) && bus.EN),
    .gap_i       (state_q == ST_GAP),
    .slot_done_o (slot_done),
    .gap_done_o  (gap_done)
  );

`ifdef SEG_SCAN_LZB_EN
  function automatic logic lead_zero(input logic [DW-1:0] act, input logic [IW-1:0] idx);
    logic all_zero;
    all_zero = 1'b1;
    for (int j = 0; j < N_DIG; j++)
      if (j >= int'(idx) && act[j*DIGIT_W +: DIGIT_W] != '0) all_zero = 1'b0;
    return (idx != '0) && all_zero;
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = 1'b0;
    if (!bus.EN) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SHOW;
          idx_d   = '0;
        end
        ST_SHOW: if (slot_done) state_d = ST_GAP;
        ST_GAP: if (gap_done) begin
          state_d = ST_SHOW;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            frame_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A LOAD landing on an apply edge bypasses the pending buffer entirely
  always_comb begin
    active_d  = active_q;
    pending_d = pending_q;
    pend_d    = pend_q;
    apply     = frame_d || (state_q == ST_IDLE);
    if (bus.LOAD) begin
      if (apply) begin
        active_d = bus.DATA;
        pend_d   = 1'b0;
      end else begin
        pending_d = bus.DATA;
        pend_d    = 1'b1;
      end
    end else if (apply && pend_q) begin
      active_d = pending_q;
      pend_d   = 1'b0;
    end
  end

  // Outputs are decoded from next state so they change on the same edge as the FSM
  always_comb begin
    an_d = '1;
    dig_d = dig_q;
    if (state_d == ST_SHOW) begin
      an_d[idx_d] = 1'b0;
      dig_d       = active_d[idx_d*DIGIT_W +: DIGIT_W];
    end
`ifdef SEG_SCAN_LZB_EN
    blank_d = (state_d != ST_SHOW) || lead_zero(active_d, idx_d);
`else
    blank_d = (state_d != ST_SHOW);
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      active_q  <= '0;
      pending_q <= '0;
      pend_q    <= 1'b0;
      frame_q   <= 1'b0;
      dig_q     <= '0;
      an_q      <= '1;
      blank_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pend_q    <= pend_d;
      frame_q   <= frame_d;
      dig_q     <= dig_d;
      an_q      <= an_d;
      blank_q   <= blank_d;
    end
  end

  assign bus.PEND      = pend_q;
  assign bus.FRAME     = frame_q;
  assign bus.DIG_NUM   = dig_q;
  assign bus.AN        = an_q;
  assign bus.SEG_BLANK = blank_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl (N_DIG=4, SLOT=4, BLANK=2)
`timescale 1ns/1ps
module tb_seg_scan_ctrl;
  logic CLK = 1'b0;
  logic RST_N;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   k;

  seg_scan_ctrl_if #(.N_DIG(4)) bus ();

  seg_scan_ctrl #(
    .N_DIG     (4),
    .SLOT_CYC  (4),
    .BLANK_CYC (2)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    k++;
  endtask

  // Cycle k after the enabling edge: 6-cycle slots (4 lit + 2 dark), 24-cycle frames
  function automatic logic [3:0] exp_an(input int kk);
    logic [3:0] a;
    a = 4'hF;
    if (kk % 6 < 4) a[(kk / 6) % 4] = 1'b0;
    return a;
  endfunction

  task automatic step_chk(input logic [15:0] code, input logic pend);
    int d;
    tick();
    d = (k / 6) % 4;
    check_eq($sformatf("an@%0d", k), 32'(bus.AN), 32'(exp_an(k)));
    check_eq($sformatf("dig@%0d", k), 32'(bus.DIG_NUM), 32'(code[d*4 +: 4]));
    check_eq($sformatf("frame@%0d", k), 32'(bus.FRAME), 32'(k > 0 && k % 24 == 0));
    check_eq($sformatf("blank@%0d", k), 32'(bus.SEG_BLANK), 32'(k % 6 >= 4));
    check_eq($sformatf("pend@%0d", k), 32'(bus.PEND), 32'(pend));
  endtask

  task automatic load(input logic [15:0] data, input logic [15:0] code, input logic pend);
    bus.LOAD = 1'b1;
    bus.DATA = data;
    step_chk(code, pend);
    bus.LOAD = 1'b0;
  endtask

  initial begin
    logic [3:0] lzb_mask;
    logic [15:0] lz_code;
    int d;
`ifdef SEG_SCAN_LZB_EN
    lzb_mask = 4'b1100;
`else
    lzb_mask = 4'b0000;
`endif
    lz_code = 16'h0050;
    RST_N = 1'b0;
    bus.EN = 1'b0;
    bus.LOAD = 1'b0;
    bus.DATA = '0;
    k = 0;

    // 1. reset state
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_an", 32'(bus.AN), 32'hF);
    check_eq("rst_blank", 32'(bus.SEG_BLANK), 32'h1);
    check_eq("rst_dig", 32'(bus.DIG_NUM), 32'h0);
    check_eq("rst_pend", 32'(bus.PEND), 32'h0);
    check_eq("rst_frame", 32'(bus.FRAME), 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;

    // 2. load in IDLE then scan two frames
    bus.LOAD = 1'b1;
    bus.DATA = 16'h4321;
    tick();
    bus.LOAD = 1'b0;
    check_eq("idle_load_pend", 32'(bus.PEND), 32'h0);
    check_eq("idle_an", 32'(bus.AN), 32'hF);
    bus.EN = 1'b1;
    k = -1;
    step_chk(16'h4321, 1'b0);
    while (k < 50) step_chk(16'h4321, 1'b0);

    // 3. mid-frame load waits for the frame edge at k=72
    load(16'hABCD, 16'h4321, 1'b1);
    while (k < 71) step_chk(16'h4321, 1'b1);
    while (k < 98) step_chk(16'hABCD, 1'b0);

    // 4. last-wins pending, then a load coincident with the frame edge at k=144
    load(16'h1111, 16'hABCD, 1'b1);
    while (k < 100) step_chk(16'hABCD, 1'b1);
    load(16'h2222, 16'hABCD, 1'b1);
    while (k < 119) step_chk(16'hABCD, 1'b1);
    while (k < 130) step_chk(16'h2222, 1'b0);
    load(16'h1111, 16'h2222, 1'b1);
    while (k < 143) step_chk(16'h2222, 1'b1);
    load(16'h5678, 16'h5678, 1'b0);
    while (k < 158) step_chk(16'h5678, 1'b0);

    // 5. drop EN during digit 2, then restart from digit 0
    bus.EN = 1'b0;
    tick();
    check_eq("en_off_an", 32'(bus.AN), 32'hF);
    check_eq("en_off_blank", 32'(bus.SEG_BLANK), 32'h1);
    for (int i = 0; i < 12; i++) begin
      tick();
      check_eq($sformatf("en_off_frame%0d", i), 32'(bus.FRAME), 32'h0);
      check_eq($sformatf("en_off_an%0d", i), 32'(bus.AN), 32'hF);
    end
    bus.EN = 1'b1;
    k = -1;
    while (k < 26) step_chk(16'h5678, 1'b0);

    // 6. async reset mid-SHOW discards pending data
    load(16'h9999, 16'h5678, 1'b1);
    #2;
    RST_N = 1'b0;
    #1;
    check_eq("async_an", 32'(bus.AN), 32'hF);
    check_eq("async_blank", 32'(bus.SEG_BLANK), 32'h1);
    check_eq("async_pend", 32'(bus.PEND), 32'h0);
    check_eq("async_dig", 32'(bus.DIG_NUM), 32'h0);
    bus.EN = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    tick();
    check_eq("post_rst_pend", 32'(bus.PEND), 32'h0);
    bus.EN = 1'b1;
    tick();
    check_eq("post_rst_an", 32'(bus.AN), 32'hE);
    check_eq("post_rst_dig", 32'(bus.DIG_NUM), 32'h0);
    check_eq("post_rst_blank", 32'(bus.SEG_BLANK), 32'h0);
    bus.EN = 1'b0;
    tick();
    bus.LOAD = 1'b1;
    bus.DATA = lz_code;
    tick();
    bus.LOAD = 1'b0;
    bus.EN = 1'b1;
    k = -1;
    for (int i = 0; i < 24; i++) begin
      tick();
      d = (k / 6) % 4;
      check_eq($sformatf("lz_an@%0d", k), 32'(bus.AN), 32'(exp_an(k)));
      check_eq($sformatf("lz_dig@%0d", k), 32'(bus.DIG_NUM), 32'(lz_code[d*4 +: 4]));
      check_eq($sformatf("lz_blank@%0d", k), 32'(bus.SEG_BLANK),
               32'((k % 6 >= 4) || lzb_mask[d]));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
